// File: rtl/fib_stream_checker_if.sv
// Valid/ready sample stream from the Fibonacci LED generator into its checker.
interface fib_stream_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/fib_stream_checker.sv
// Checks that each accepted sample is the modular sum of the previous two;
// reports lock, sticky error with offending/expected value, and match count.
module fib_stream_checker #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  fib_stream_checker_if.slave  bus,
  output logic                 locked,
  output logic                 err,
  output logic [WIDTH-1:0]     err_data,
  output logic [WIDTH-1:0]     exp_data,
  output logic [CNT_W-1:0]     match_count,
  output logic [7:0]           led
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, ERROR = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] last, prev, exp_sum, last_nxt, prev_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       state_code;
  logic [3:0]       led_val;
  logic             accept, hit;

  assign exp_sum  = last + prev;
  assign accept   = bus.in_valid && bus.in_ready;
  assign hit      = (bus.in_data == exp_sum);
  assign last_nxt = (accept && hit) ? bus.in_data : last;
  assign prev_nxt = (accept && hit) ? last : prev;
  assign cnt_nxt  = (match_count == '1) ? match_count : match_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart)     state_nxt = IDLE;
    else if (accept) state_nxt = hit ? CHECK : ERROR;
  end

  always_comb begin
    bus.in_ready = (state != ERROR) && !restart && !reset;
    state_code   = state;
  end

  // Mismatch holds last/prev, so last_nxt+prev_nxt also freezes exp_data at exp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last        <= '0;
      prev        <= WIDTH'(1);
      err         <= 1'b0;
      locked      <= 1'b0;
      match_count <= '0;
      err_data    <= '0;
      exp_data    <= WIDTH'(1);
    end else if (restart) begin
      last        <= '0;
      prev        <= WIDTH'(1);
      err         <= 1'b0;
      locked      <= 1'b0;
      match_count <= '0;
      err_data    <= '0;
      exp_data    <= WIDTH'(1);
    end else begin
      if (state != ERROR) exp_data <= last_nxt + prev_nxt;
      if (accept) begin
        if (hit) begin
          last        <= last_nxt;
          prev        <= prev_nxt;
          match_count <= cnt_nxt;
          if (cnt_nxt >= CNT_W'(LOCK_N)) locked <= 1'b1;
        end else begin
          err      <= 1'b1;
          err_data <= bus.in_data;
          locked   <= 1'b0;
        end
      end
    end
  end

  generate
    if (WIDTH >= 4) begin : g_led_wide
      assign led_val = last[3:0];
    end else begin : g_led_narrow
      assign led_val = {{(4-WIDTH){1'b0}}, last};
    end
  endgenerate

  assign led = {led_val, err, locked, state_code};

endmodule
